corner_coord_collector: RTL and testbench
=========================================

// Module: corner_coord_collector
// PURPOSE
//  Downstream consumer of the non-max-suppression stage. Counts raster position over the per-pixel
//  {i_is_corner, i_v} stream and discards corners inside the invalid border margin. Queues surviving
//  corner (x,y) coordinates in a FIFO and emits them on a valid/ready stream, followed by an
//  end-of-frame word carrying the frame's corner count. This is the hand-off from the FAST pipeline
//  to the DMA/host side.
// PARAMETERS
//  RES_X   320  pixels per line; one i_v beat per pixel
//  RES_Y   240  lines per frame
//  MARGIN  6    border width in pixels (3 circle + 3 NMS); corners in the border are invalid
//  DEPTH   64   FIFO entries; power of two, >= 4
// PORTS
//  i_clk          in   1   clock; all logic on posedge
//  i_rst          in   1   synchronous, active-high reset
//  i_is_corner    in   1   corner flag for the current pixel; qualified by i_v
//  i_v            in   1   pixel beat valid; beats arrive in raster order, no backpressure
//  o_data         out  32  output word (format below)
//  o_valid        out  1   o_data valid
//  i_ready        in   1   consumer accepts o_data when o_valid && i_ready
//  o_overflow     out  1   sticky flag: a corner or EOF word was dropped in the current frame
//  o_drop_cnt     out  16  dropped corners this frame; saturates at 16'hFFFF
// BEHAVIOUR
//  Reset: x_cnt=0, y_cnt=0, FIFO empty, eof_pending=0, corner_cnt=0.
//   Outputs: o_valid=0, o_data=0, o_overflow=0, o_drop_cnt=0.
//  Position counters advance only on i_v beats.
//   x_cnt wraps RES_X-1 -> 0 and increments y_cnt.
//   y_cnt wraps RES_Y-1 -> 0, which starts a new frame.
//  Keep test: corner kept iff i_v && i_is_corner, MARGIN <= x_cnt < RES_X-MARGIN,
//   and MARGIN <= y_cnt < RES_Y-MARGIN. All other flags are ignored.
//  Corner word: {1'b0, 15'(y_cnt), 16'(x_cnt)}.
//  EOF word: {1'b1, 15'd0, corner_cnt}.
//   corner_cnt = corners written to the FIFO this frame; saturates at 16'hFFFF.
//  Write rule: a write happens only when occupancy < DEPTH, evaluated before a same-cycle pop.
//   A pop in the same cycle does not make room for that cycle's write.
//  Corner arriving when the FIFO is full:
//   - word is dropped; o_overflow <= 1; o_drop_cnt increments (saturating)
//   - corner_cnt does not increment
//  EOF on the last beat of a frame (x_cnt=RES_X-1, y_cnt=RES_Y-1):
//   - eof_pending is set
//   - this beat can never be a kept corner (MARGIN>0), so a corner write and an EOF never collide
//  EOF write: pending EOF has priority on the FIFO write port; it is written on the first cycle
//   with occupancy < DEPTH and clears eof_pending.
//  EOF still pending when the next frame's first kept corner arrives: that corner is dropped and
//   counted against the new frame.
//  Frame-start clear: on the first beat of a frame (x=0, y=0 with i_v), corner_cnt, o_drop_cnt and
//   o_overflow are cleared.
//   - This happens after the previous EOF word has captured corner_cnt.
//   - The snapshot is taken into the EOF word when eof_pending is set.
//  Latency: i_v beat sampled at edge N with an empty FIFO -> o_valid=1 with that word after edge N+1.
//  Output stream:
//   - first-word-fall-through with a registered read
//   - o_data is stable while o_valid && !i_ready
//   - o_valid deasserts only after the last word is popped
//   - back-to-back pops give one word per cycle
//  Occupancy counter width is $clog2(DEPTH)+1; pointers wrap modulo DEPTH.
//  Mid-operation reset: all state returns to reset values in one edge.
//   FIFO contents and any pending EOF are discarded; the counters restart at pixel (0,0).
// STRUCTURE
//  fast_pkg holds RES_X/RES_Y defaults, the MARGIN constant, the EOF bit index (31) and a
//   typedef for the 32-bit out word.
//  One sub-module, sync_fifo (WIDTH=32, DEPTH): FWFT, registered read, occupancy output.
//  The top level owns the position counters, keep test, EOF pending register and statistics.
// TESTING
//  1 Single kept corner at (10,20), i_ready=1 -> exactly one word 32'h0014_000A,
//    o_valid high 2 cycles after the beat.
//  2 Corners at (3,50) and (316,50) with RES_X=320 -> both dropped.
//    Frame ends -> one EOF word 32'h8000_0000.
//  3 i_ready=0, 70 kept corners in one frame (DEPTH=64):
//    - 64 corners queued, o_overflow=1, o_drop_cnt=6
//    - EOF becomes pending; raising i_ready drains the 64 corners, then 32'h8000_0040
//  4 Corner arrives when FIFO full while a pop happens the same cycle -> that corner is dropped.
//    The next cycle's corner is accepted.
//  5 Reset asserted for 1 cycle mid-frame with 5 queued words:
//    - o_valid=0 next cycle, FIFO empty
//    - a corner at (6,6) in the next frame is the first word out
//  6 Two consecutive frames, 3 then 1 kept corners, i_ready=1 ->
//    stream C,C,C,EOF(3),C,EOF(1); o_drop_cnt=0 throughout.

Source files
------------

// File: rtl/corner_coord_collector_pkg.sv
// Shared constants, output word type and small helpers for the corner coordinate collector.
// Output word: bit 31 set marks an end-of-frame word carrying the frame's corner count.
package corner_coord_collector_pkg;

  localparam int RES_X_DEF = 320;
  localparam int RES_Y_DEF = 240;
  localparam int DEPTH_DEF = 64;
  localparam int MARGIN    = 6;
  localparam int EOF_BIT   = 31;

  localparam logic [15:0] CNT_SAT = 16'hFFFF;

  typedef logic [31:0] out_word_t;

  function automatic out_word_t corner_word(input logic [15:0] x, input logic [14:0] y);
    out_word_t w;
    w          = '0;
    w[15:0]    = x;
    w[30:16]   = y;
    return w;
  endfunction

  function automatic out_word_t eof_word(input logic [15:0] cnt);
    out_word_t w;
    w          = '0;
    w[EOF_BIT] = 1'b1;
    w[15:0]    = cnt;
    return w;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == CNT_SAT) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/corner_coord_collector_if.sv
// Valid/ready output stream from the collector towards the DMA/host side.
interface corner_coord_collector_if;
  import corner_coord_collector_pkg::*;

  out_word_t o_data;
  logic      o_valid;
  logic      i_ready;

  modport master (output o_data, output o_valid, input i_ready);
  modport slave  (input o_data, input o_valid, output i_ready);

endinterface

// File: rtl/corner_coord_collector_sync_fifo.sv
// First-word-fall-through FIFO with a registered read port and an occupancy count that
// includes the word currently presented on the output.
module corner_coord_collector_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_wr_en,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_ready,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic                     o_rd_valid,
  output logic [$clog2(DEPTH):0]   o_occupancy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_rd_data;
  logic             r_rd_valid;

  logic             w_push;
  logic             w_pop;
  logic [AW-1:0]    w_rd_next;

  // Room is judged on the count before this cycle's pop takes effect.
  assign w_push    = i_wr_en && (r_count < CW'(DEPTH));
  assign w_pop     = r_rd_valid && i_rd_ready;
  assign w_rd_next = r_rd_ptr + AW'(1);

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // r_rd_ptr always addresses the head word; the output register only loads words
  // written on earlier edges, so a fresh write shows up one cycle after it lands.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_pop) begin
        r_rd_ptr <= w_rd_next;
        if (r_count > CW'(1)) begin
          r_rd_data  <= r_mem[w_rd_next];
          r_rd_valid <= 1'b1;
        end else begin
          r_rd_valid <= 1'b0;
        end
      end else if (!r_rd_valid && (r_count != '0)) begin
        r_rd_data  <= r_mem[r_rd_ptr];
        r_rd_valid <= 1'b1;
      end
    end
  end

  assign o_rd_data   = r_rd_data;
  assign o_rd_valid  = r_rd_valid;
  assign o_occupancy = r_count;

endmodule

// File: rtl/corner_coord_collector.sv
// Tracks raster position over the pixel beat stream, keeps corners outside the border margin,
// queues their coordinates and closes each frame with an end-of-frame count word.
module corner_coord_collector
  import corner_coord_collector_pkg::*;
#(
  parameter int RES_X = RES_X_DEF,
  parameter int RES_Y = RES_Y_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_is_corner,
  input  logic                     i_v,
  corner_coord_collector_if.master m_out,
  output logic                     o_overflow,
  output logic [15:0]              o_drop_cnt
);
  localparam int XW = $clog2(RES_X);
  localparam int YW = $clog2(RES_Y);
  localparam int OW = $clog2(DEPTH) + 1;

  localparam logic [XW-1:0] X_LAST = XW'(RES_X - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(RES_Y - 1);
  localparam logic [XW-1:0] X_LO   = XW'(MARGIN);
  localparam logic [XW-1:0] X_HI   = XW'(RES_X - MARGIN);
  localparam logic [YW-1:0] Y_LO   = YW'(MARGIN);
  localparam logic [YW-1:0] Y_HI   = YW'(RES_Y - MARGIN);

  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          r_eof_pending;
  logic [15:0]   r_eof_cnt;
  logic [15:0]   r_corner_cnt;
  logic [15:0]   r_drop_cnt;
  logic          r_overflow;

  logic          w_first;
  logic          w_last;
  logic          w_keep;
  logic          w_full;
  logic          w_eof_wr;
  logic          w_corner_wr;
  logic          w_corner_drop;
  logic          w_wr_en;
  out_word_t     w_wr_data;
  logic [OW-1:0] w_occ;

  assign w_first = i_v && (r_x == '0) && (r_y == '0);
  assign w_last  = i_v && (r_x == X_LAST) && (r_y == Y_LAST);
  assign w_keep  = i_v && i_is_corner &&
                   (r_x >= X_LO) && (r_x < X_HI) &&
                   (r_y >= Y_LO) && (r_y < Y_HI);
  assign w_full  = (w_occ == OW'(DEPTH));

  // A pending EOF owns the write port; any kept corner seen while it waits is lost.
  assign w_eof_wr      = r_eof_pending && !w_full;
  assign w_corner_wr   = w_keep && !r_eof_pending && !w_full;
  assign w_corner_drop = w_keep && !w_corner_wr;
  assign w_wr_en       = w_eof_wr || w_corner_wr;
  assign w_wr_data     = w_eof_wr ? eof_word(r_eof_cnt) : corner_word(16'(r_x), 15'(r_y));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_v) begin
      if (r_x == X_LAST) begin
        r_x <= '0;
        r_y <= (r_y == Y_LAST) ? '0 : r_y + YW'(1);
      end else begin
        r_x <= r_x + XW'(1);
      end
    end
  end

  // The count is snapshotted on the last beat, so the frame-start clear that follows
  // can never disturb the EOF word still waiting for room.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_eof_pending <= 1'b0;
      r_eof_cnt     <= '0;
    end else if (w_last) begin
      r_eof_pending <= 1'b1;
      r_eof_cnt     <= r_corner_cnt;
    end else if (w_eof_wr) begin
      r_eof_pending <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_corner_cnt <= '0;
      r_drop_cnt   <= '0;
      r_overflow   <= 1'b0;
    end else if (w_first) begin
      r_corner_cnt <= '0;
      r_drop_cnt   <= '0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_corner_wr) begin
        r_corner_cnt <= sat_inc(r_corner_cnt);
      end
      if (w_corner_drop) begin
        r_overflow <= 1'b1;
        r_drop_cnt <= sat_inc(r_drop_cnt);
      end
      // The previous frame's EOF is overwritten before it ever reached the FIFO.
      if (w_last && r_eof_pending && !w_eof_wr) begin
        r_overflow <= 1'b1;
      end
    end
  end

  corner_coord_collector_sync_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_wr_en     (w_wr_en),
    .i_wr_data   (w_wr_data),
    .i_rd_ready  (m_out.i_ready),
    .o_rd_data   (m_out.o_data),
    .o_rd_valid  (m_out.o_valid),
    .o_occupancy (w_occ)
  );

  assign o_overflow = r_overflow;
  assign o_drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_corner_coord_collector.sv
// Directed bench for corner_coord_collector on a reduced 40x32 frame so several frames fit.
module tb_corner_coord_collector;
  import corner_coord_collector_pkg::*;

  localparam int RX = 40;
  localparam int RY = 32;
  localparam int DP = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        is_corner = 1'b0;
  logic        v = 1'b0;
  logic        overflow;
  logic [15:0] drop_cnt;

  corner_coord_collector_if bus();

  corner_coord_collector #(.RES_X(RX), .RES_Y(RY), .DEPTH(DP)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_is_corner (is_corner),
    .i_v         (v),
    .m_out       (bus),
    .o_overflow  (overflow),
    .o_drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int px = 0;
  int py = 0;
  logic [31:0] q[$];
  logic [31:0] exp_q[$];

  // Words accepted at the coming edge are recorded half a cycle before it.
  always @(negedge clk) begin
    if (!rst && bus.o_valid && bus.i_ready) q.push_back(bus.o_data);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] cw(input int x, input int y);
    return {1'b0, 15'(y), 16'(x)};
  endfunction

  function automatic logic [31:0] ew(input int n);
    return {16'h8000, 16'(n)};
  endfunction

  task automatic pix(input logic c);
    v = 1'b1;
    is_corner = c;
    @(posedge clk);
    #1;
    v = 1'b0;
    is_corner = 1'b0;
    if (px == RX - 1) begin
      px = 0;
      py = (py == RY - 1) ? 0 : py + 1;
    end else begin
      px++;
    end
  endtask

  task automatic goto(input int x, input int y);
    while (!(px == x && py == y)) pix(1'b0);
  endtask

  task automatic corner_at(input int x, input int y);
    goto(x, y);
    pix(1'b1);
  endtask

  task automatic end_frame();
    do pix(1'b0); while (!(px == 0 && py == 0));
  endtask

  task automatic cmp_stream(input string tag);
    for (int i = 0; i < 400 && q.size() < exp_q.size(); i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_len"}, 32'(q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      chk(tag, (i < q.size()) ? q[i] : 32'hDEAD_BEEF, exp_q[i]);
    q.delete();
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_data", bus.o_data, 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    rst = 1'b0;

    // single kept corner and its latency
    bus.i_ready = 1'b1;
    corner_at(10, 20);
    chk("t1_valid_n", 32'(bus.o_valid), 32'd0);
    pix(1'b0);
    chk("t1_valid_n1", 32'(bus.o_valid), 32'd1);
    chk("t1_data", bus.o_data, 32'h0014_000A);
    end_frame();
    exp_q = '{32'h0014_000A, 32'h8000_0001};
    cmp_stream("t1");

    // border corners are ignored, not counted as drops
    corner_at(10, 5);
    corner_at(3, 10);
    corner_at(34, 10);
    corner_at(10, 26);
    chk("t2_drop", 32'(drop_cnt), 32'd0);
    chk("t2_ovf", 32'(overflow), 32'd0);
    end_frame();
    exp_q = '{32'h8000_0000};
    cmp_stream("t2");

    // two frames, inner-boundary corners kept
    corner_at(6, 6);
    corner_at(20, 10);
    corner_at(33, 25);
    end_frame();
    chk("t6_drop_a", 32'(drop_cnt), 32'd0);
    corner_at(15, 12);
    end_frame();
    chk("t6_drop_b", 32'(drop_cnt), 32'd0);
    exp_q = '{32'h0006_0006, 32'h000A_0014, 32'h0019_0021, 32'h8000_0003,
              32'h000C_000F, 32'h8000_0001};
    cmp_stream("t6");

    // 70 corners into a stalled 64-deep FIFO
    bus.i_ready = 1'b0;
    begin
      int n = 0;
      for (int y = 6; y <= 8; y++)
        for (int x = 6; x <= 33; x++)
          if (n < 70) begin
            corner_at(x, y);
            if (n < DP) exp_q.push_back(cw(x, y));
            n++;
          end
    end
    end_frame();
    repeat (2) @(posedge clk);
    #1;
    chk("t3_ovf", 32'(overflow), 32'd1);
    chk("t3_drop", 32'(drop_cnt), 32'd6);
    chk("t3_valid", 32'(bus.o_valid), 32'd1);
    chk("t3_head", bus.o_data, 32'h0006_0006);
    exp_q.push_back(ew(64));
    bus.i_ready = 1'b1;
    cmp_stream("t3");
    chk("t3_ovf_sticky", 32'(overflow), 32'd1);
    pix(1'b0);
    chk("t3_clr_ovf", 32'(overflow), 32'd0);
    chk("t3_clr_drop", 32'(drop_cnt), 32'd0);

    // full FIFO with a same-cycle pop still drops the arriving corner
    bus.i_ready = 1'b0;
    begin
      int n = 0;
      for (int y = 6; y <= 8; y++)
        for (int x = 6; x <= 33; x++)
          if (n < DP) begin
            corner_at(x, y);
            exp_q.push_back(cw(x, y));
            n++;
          end
    end
    bus.i_ready = 1'b1;
    corner_at(14, 8);
    bus.i_ready = 1'b0;
    corner_at(15, 8);
    chk("t4_drop", 32'(drop_cnt), 32'd1);
    chk("t4_ovf", 32'(overflow), 32'd1);
    exp_q.push_back(cw(15, 8));
    bus.i_ready = 1'b1;
    end_frame();
    exp_q.push_back(ew(65));
    cmp_stream("t4");

    // reset mid-frame with queued words
    bus.i_ready = 1'b0;
    for (int x = 8; x <= 12; x++) corner_at(x, 7);
    pix(1'b0);
    pix(1'b0);
    chk("t5_valid_pre", 32'(bus.o_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_valid", 32'(bus.o_valid), 32'd0);
    chk("t5_data", bus.o_data, 32'd0);
    rst = 1'b0;
    px = 0;
    py = 0;
    bus.i_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t5_empty", 32'(bus.o_valid), 32'd0);
    corner_at(6, 6);
    end_frame();
    exp_q = '{32'h0006_0006, 32'h8000_0001};
    cmp_stream("t5");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
